nvdla_hwpe2dbb_burst: RTL and testbench

NVDLA_HWPE2DBB_BURST -- requirements
Module: nvdla_hwpe2dbb_burst

---
 rtl/nvdla_hwpe2dbb_burst.sv | 138 +++++++++++++
 tb/tb_nvdla_hwpe2dbb_burst.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_hwpe2dbb_burst.sv
// Burst bridge between an HWPE-style request/stream port and the DBB streamers.
// One burst at a time: latch the request, kick the streamer, pass beats through, close out.
module nvdla_hwpe2dbb_burst #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [LEN_W-1:0]    req_len_i,
  input  logic [ID_W-1:0]     req_id_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wdata_strb_i,
  output logic                wrsp_valid_o,
  input  logic                wrsp_ready_i,
  output logic [ID_W-1:0]     wrsp_id_o,
  output logic                rdata_valid_o,
  input  logic                rdata_ready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ID_W-1:0]     rdata_id_o,
  output logic                rdata_last_o,
  output logic                sink_req_start_o,
  input  logic                sink_ready_start_i,
  output logic                source_req_start_o,
  input  logic                source_ready_start_i,
  output logic [ADDR_W-1:0]   str_base_addr_o,
  output logic [LEN_W:0]      str_trans_size_o,
  output logic                dbb_o_valid_o,
  input  logic                dbb_o_ready_i,
  output logic [DATA_W-1:0]   dbb_o_data_o,
  output logic [DATA_W/8-1:0] dbb_o_strb_o,
  input  logic                dbb_i_valid_i,
  output logic                dbb_i_ready_o,
  input  logic [DATA_W-1:0]   dbb_i_data_i,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_START, S_WR_DATA, S_WR_RSP, S_RD_START, S_RD_DATA, S_DRAIN
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [ID_W-1:0]     id_q;
  logic [LEN_W:0]      size_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    cnt_d;

  logic in_wr_data, in_rd_data, last_beat;
  logic req_fire, wr_fire, rd_fire, rsp_fire;

  // Every channel is valid/ready: a beat transfers in a cycle where both are 1;
  // the producer holds valid and payload until that cycle.
  assign in_wr_data = (state_q == S_WR_DATA);
  assign in_rd_data = (state_q == S_RD_DATA);
  assign last_beat  = (cnt_q == len_q);
  assign cnt_d      = cnt_q + LEN_W'(1);

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign req_fire    = req_ready_o && req_valid_i;

  assign sink_req_start_o   = (state_q == S_WR_START) && sink_ready_start_i;
  assign source_req_start_o = (state_q == S_RD_START) && source_ready_start_i;

  // Write beats flow straight through so a fully ready stream sees no bubbles.
  assign dbb_o_valid_o = in_wr_data && wdata_valid_i;
  assign wdata_ready_o = in_wr_data && dbb_o_ready_i;
  assign dbb_o_data_o  = in_wr_data ? wdata_i : '0;
  assign dbb_o_strb_o  = in_wr_data ? wdata_strb_i : '0;
  assign wr_fire       = dbb_o_valid_o && wdata_ready_o;

  // The response waits until the write streamer reports idle, i.e. data is committed.
  assign wrsp_valid_o = (state_q == S_WR_RSP) && sink_ready_start_i;
  assign wrsp_id_o    = (state_q == S_WR_RSP) ? id_q : '0;
  assign rsp_fire     = wrsp_valid_o && wrsp_ready_i;

  assign rdata_valid_o = in_rd_data && dbb_i_valid_i;
  assign dbb_i_ready_o = in_rd_data && rdata_ready_i;
  assign rdata_o       = in_rd_data ? dbb_i_data_i : '0;
  assign rdata_id_o    = in_rd_data ? id_q : '0;
  assign rdata_last_o  = in_rd_data && last_beat;
  assign rd_fire       = rdata_valid_o && dbb_i_ready_o;

  assign str_base_addr_o  = addr_q;
  assign str_trans_size_o = size_q;
  assign dbg_state_o      = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            addr_q  <= req_addr_i;
            len_q   <= req_len_i;
            id_q    <= req_id_i;
            // Computed one bit wider so the maximum length does not wrap to zero.
            size_q  <= {1'b0, req_len_i} + (LEN_W+1)'(1);
            cnt_q   <= '0;
            state_q <= req_we_i ? S_WR_START : S_RD_START;
          end
        end
        S_WR_START: if (sink_ready_start_i) state_q <= S_WR_DATA;
        S_WR_DATA: begin
          if (wr_fire) begin
            cnt_q <= cnt_d;
            if (last_beat) state_q <= S_WR_RSP;
          end
        end
        S_WR_RSP:   if (rsp_fire) state_q <= S_IDLE;
        S_RD_START: if (source_ready_start_i) state_q <= S_RD_DATA;
        S_RD_DATA: begin
          if (rd_fire) begin
            cnt_q <= cnt_d;
            if (last_beat) state_q <= S_DRAIN;
          end
        end
        S_DRAIN:    if (source_ready_start_i) state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_hwpe2dbb_burst.sv
// Bench for nvdla_hwpe2dbb_burst: a table of directed bursts, a mid-burst reset
// sequence and randomized bursts checked against a beat-counting reference model.
module tb_nvdla_hwpe2dbb_burst;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i, req_id_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [63:0] wdata_i;
  logic [7:0]  wdata_strb_i;
  logic        wrsp_valid_o, wrsp_ready_i;
  logic [7:0]  wrsp_id_o;
  logic        rdata_valid_o, rdata_ready_i;
  logic [63:0] rdata_o;
  logic [7:0]  rdata_id_o;
  logic        rdata_last_o;
  logic        sink_req_start_o, sink_ready_start_i;
  logic        source_req_start_o, source_ready_start_i;
  logic [31:0] str_base_addr_o;
  logic [8:0]  str_trans_size_o;
  logic        dbb_o_valid_o, dbb_o_ready_i;
  logic [63:0] dbb_o_data_o;
  logic [7:0]  dbb_o_strb_o;
  logic        dbb_i_valid_i, dbb_i_ready_o;
  logic [63:0] dbb_i_data_i;
  logic [2:0]  dbg_state_o;

  int n_chk  = 0;
  int n_fail = 0;

  nvdla_hwpe2dbb_burst dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_id_i(req_id_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i), .wdata_strb_i(wdata_strb_i),
    .wrsp_valid_o(wrsp_valid_o), .wrsp_ready_i(wrsp_ready_i), .wrsp_id_o(wrsp_id_o),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .rdata_id_o(rdata_id_o), .rdata_last_o(rdata_last_o),
    .sink_req_start_o(sink_req_start_o), .sink_ready_start_i(sink_ready_start_i),
    .source_req_start_o(source_req_start_o), .source_ready_start_i(source_ready_start_i),
    .str_base_addr_o(str_base_addr_o), .str_trans_size_o(str_trans_size_o),
    .dbb_o_valid_o(dbb_o_valid_o), .dbb_o_ready_i(dbb_o_ready_i),
    .dbb_o_data_o(dbb_o_data_o), .dbb_o_strb_o(dbb_o_strb_o),
    .dbb_i_valid_i(dbb_i_valid_i), .dbb_i_ready_o(dbb_i_ready_o), .dbb_i_data_i(dbb_i_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rd_pattern(input logic [7:0] id, input int beat);
    return {id, 24'hA5C3E1, 32'(beat)};
  endfunction

  function automatic logic coin(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_len_i = '0; req_id_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; wdata_strb_i = '0; wrsp_ready_i = 1'b0;
    rdata_ready_i = 1'b0; sink_ready_start_i = 1'b0; source_ready_start_i = 1'b0;
    dbb_o_ready_i = 1'b0; dbb_i_valid_i = 1'b0; dbb_i_data_i = '0;
  endtask

  // One complete burst; the model only tracks beat number, payload order and last position.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [7:0] len,
                         input logic [7:0] id, input int pct, input int start_dly,
                         input int end_dly, input logic [8:0] exp_size);
    int beats;
    int cyc;
    logic [63:0] exp_q[$];
    logic [63:0] got;
    chk("idle_before_req", req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_len_i = len; req_id_i = id;
    next_cycle();
    req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0; req_id_i = '0;
    #2;
    chk("busy_after_req", req_ready_o, 1'b0);
    for (int i = 0; i < start_dly; i++) begin
      #2;
      chk("start_wait", {sink_req_start_o, source_req_start_o}, 2'b00);
      next_cycle();
    end
    sink_ready_start_i = we; source_ready_start_i = !we;
    #2;
    chk("start_pulse", {sink_req_start_o, source_req_start_o}, {we, !we});
    chk("trans_size", str_trans_size_o, exp_size);
    chk("base_addr", str_base_addr_o, addr);
    next_cycle();
    sink_ready_start_i = 1'b0; source_ready_start_i = 1'b0;
    beats = 0; cyc = 0;
    while (beats < int'(exp_size) && cyc < 5000) begin
      if (we) begin
        wdata_valid_i = coin(pct); dbb_o_ready_i = coin(pct);
        wdata_i = {$urandom, $urandom}; wdata_strb_i = 8'($urandom);
        #2;
        chk("wr_valid_pass", dbb_o_valid_o, wdata_valid_i);
        chk("wr_ready_pass", wdata_ready_o, dbb_o_ready_i);
        if (wdata_valid_i && dbb_o_ready_i) begin
          exp_q.push_back({wdata_strb_i, 56'(wdata_i)});
          exp_q.push_back(wdata_i);
          got = exp_q.pop_front();
          chk("wr_strb", {dbb_o_strb_o, 56'(dbb_o_data_o)}, got);
          got = exp_q.pop_front();
          chk("wr_data", dbb_o_data_o, got);
          beats++;
        end
      end else begin
        dbb_i_valid_i = coin(pct); rdata_ready_i = coin(pct);
        dbb_i_data_i = rd_pattern(id, beats);
        #2;
        chk("rd_valid_pass", rdata_valid_o, dbb_i_valid_i);
        chk("rd_ready_pass", dbb_i_ready_o, rdata_ready_i);
        if (dbb_i_valid_i) begin
          chk("rd_data_order", rdata_o, rd_pattern(id, beats));
          chk("rd_last", rdata_last_o, (beats == int'(exp_size) - 1));
          chk("rd_id", rdata_id_o, id);
        end
        if (dbb_i_valid_i && rdata_ready_i) beats++;
      end
      chk("no_restart", {sink_req_start_o, source_req_start_o}, 2'b00);
      next_cycle();
      cyc++;
    end
    chk("beat_count", beats, exp_size);
    if (pct == 100) chk("zero_bubble_cycles", cyc, exp_size);
    // Offer one more beat on both streams; nothing may be accepted past the last beat.
    wdata_valid_i = 1'b1; dbb_o_ready_i = 1'b1; dbb_i_valid_i = 1'b1; rdata_ready_i = 1'b1;
    wrsp_ready_i = 1'b1;
    #2;
    chk("no_extra_beat", {wdata_ready_o, dbb_o_valid_o, rdata_valid_o, dbb_i_ready_o}, 4'b0);
    for (int i = 0; i < end_dly; i++) begin
      #2;
      chk("rsp_held_low", wrsp_valid_o, 1'b0);
      chk("no_accept_in_tail", req_ready_o, 1'b0);
      next_cycle();
    end
    wdata_valid_i = 1'b0; dbb_o_ready_i = 1'b0; dbb_i_valid_i = 1'b0; rdata_ready_i = 1'b0;
    sink_ready_start_i = we; source_ready_start_i = !we;
    #2;
    if (we) begin
      chk("wrsp_valid", wrsp_valid_o, 1'b1);
      chk("wrsp_id", wrsp_id_o, id);
    end else begin
      chk("drain_no_rsp", wrsp_valid_o, 1'b0);
    end
    next_cycle();
    sink_ready_start_i = 1'b0; source_ready_start_i = 1'b0; wrsp_ready_i = 1'b0;
    #2;
    chk("back_to_idle", req_ready_o, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    int          pct;
    int          start_dly;
    int          end_dly;
    logic [8:0]  exp_size;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1000, 8'd3,   8'h5A, 100, 0, 0, 9'd4};
    vecs[1] = '{1'b0, 32'h0000_2000, 8'd0,   8'h11, 100, 2, 3, 9'd1};
    vecs[2] = '{1'b0, 32'h0000_3000, 8'd255, 8'h22, 50,  0, 1, 9'd256};
    vecs[3] = '{1'b1, 32'h0000_4000, 8'd1,   8'h33, 100, 1, 5, 9'd2};
    vecs[4] = '{1'b1, 32'hFFFF_FFF0, 8'd255, 8'hFF, 70,  0, 0, 9'd256};

    idle_inputs();
    rst_i = 1'b1;
    repeat (3) next_cycle();
    #2;
    chk("rst_handshakes", {req_ready_o, wdata_ready_o, dbb_o_valid_o, wrsp_valid_o,
                           rdata_valid_o, dbb_i_ready_o, sink_req_start_o, source_req_start_o}, 8'h00);
    chk("rst_size", str_trans_size_o, 9'd0);
    rst_i = 1'b0;
    #1;
    chk("ready_after_release", req_ready_o, 1'b1);
    next_cycle();

    foreach (vecs[i])
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].id, vecs[i].pct,
              vecs[i].start_dly, vecs[i].end_dly, vecs[i].exp_size);

    // Reset asserted asynchronously while beat 2 of a write is on the bus.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'hABC0; req_len_i = 8'd5; req_id_i = 8'h77;
    next_cycle();
    req_valid_i = 1'b0;
    sink_ready_start_i = 1'b1;
    next_cycle();
    sink_ready_start_i = 1'b0;
    wdata_valid_i = 1'b1; dbb_o_ready_i = 1'b1; wdata_i = 64'h1234; wdata_strb_i = 8'hFF;
    repeat (2) next_cycle();
    #2;
    chk("pre_reset_beat", dbb_o_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("midburst_rst_handshakes", {req_ready_o, wdata_ready_o, dbb_o_valid_o, wrsp_valid_o,
                                    rdata_valid_o, dbb_i_ready_o, sink_req_start_o, source_req_start_o}, 8'h00);
    chk("midburst_rst_addr", str_base_addr_o, 32'h0);
    chk("midburst_rst_size", str_trans_size_o, 9'd0);
    next_cycle();
    idle_inputs();
    rst_i = 1'b0;
    #2;
    chk("ready_after_midburst_rst", req_ready_o, 1'b1);
    run_txn(1'b0, 32'h0000_5000, 8'd4, 8'h44, 100, 0, 1, 9'd5);

    // Randomized bursts.
    for (int t = 0; t < 10; t++) begin
      logic [7:0] rl;
      rl = 8'($urandom_range(0, 20));
      run_txn(1'($urandom_range(1)), $urandom, rl, 8'($urandom), $urandom_range(30, 100),
              $urandom_range(0, 3), $urandom_range(0, 3), 9'(int'(rl) + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
